leitor_joystick_genesis: RTL

- Upstream input stage feeding Controlador.Entradas.
- Drives the Select line of a Sega Genesis/Mega Drive 3-button pad once per video frame and samples the six pad pins in both Select phases.
- Detects whether a pad is attached, debounces the buttons across frames, and presents a stable 12-bit word plus one-cycle press pulses.
- Frame timing comes from VGA v_sync, so robot commands update at most once per frame.

---
 rtl/joystick_pkg.sv | 25 ++
 rtl/sincronizador_2ff.sv | 23 ++
 rtl/leitor_joystick_genesis.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/joystick_pkg.sv
// Shared constants for the Genesis pad reader: FSM encoding, Saidas bit map and widths.
package joystick_pkg;

  typedef logic [2:0] estado_t;

  localparam estado_t OCIOSO        = 3'd0;
  localparam estado_t ESPERA_ALTO   = 3'd1;
  localparam estado_t AMOSTRA_ALTO  = 3'd2;
  localparam estado_t ESPERA_BAIXO  = 3'd3;
  localparam estado_t AMOSTRA_BAIXO = 3'd4;
  localparam estado_t ATUALIZA      = 3'd5;

  localparam int BIT_UP       = 0;
  localparam int BIT_DOWN     = 1;
  localparam int BIT_LEFT     = 2;
  localparam int BIT_RIGHT    = 3;
  localparam int BIT_A        = 4;
  localparam int BIT_B        = 5;
  localparam int BIT_C        = 6;
  localparam int BIT_START    = 7;
  localparam int BIT_PRESENTE = 8;

  localparam int LARGURA_SAIDAS = 12;

endpackage

// File: rtl/sincronizador_2ff.sv
// Two-flop synchronizer for a bus of independent asynchronous single-bit signals.
module sincronizador_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] dado,
  output logic [WIDTH-1:0] sinc
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      sinc <= '0;
    end else begin
      meta <= dado;
      sinc <= meta;
    end
  end

endmodule

// File: rtl/leitor_joystick_genesis.sv
// Sega Genesis 3-button pad reader: one two-phase Select scan per VGA frame,
// pad presence detection, frame-based debounce and one-cycle press pulses.
module leitor_joystick_genesis
  import joystick_pkg::*;
#(
  parameter int SETTLE_CYCLES   = 500,
  parameter int DEBOUNCE_FRAMES = 2
) (
  input  logic                      Clock50,
  input  logic                      Reset,
  input  logic                      Pino1,
  input  logic                      Pino2,
  input  logic                      Pino3,
  input  logic                      Pino4,
  input  logic                      Pino6,
  input  logic                      Pino9,
  input  logic                      v_sync,
  output logic                      Select,
  output logic [LARGURA_SAIDAS-1:0] Saidas,
  output logic [7:0]                Pulsos,
  output logic                      Quadro_ok
);

  localparam int                CNT_W  = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  FIM    = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [3:0]        LIMIAR = 4'(DEBOUNCE_FRAMES);

  logic [6:0]       pinos_sinc;
  logic             p1, p2, p3, p4, p6, p9, vs_sinc;
  logic             vs_anterior;
  logic             inicio_quadro;
  estado_t          estado;
  logic [CNT_W-1:0] cnt_espera;
  logic [7:0]       botoes;
  logic             presente;
  logic [8:0]       bruto;
  logic [8:0]       candidato;
  logic [3:0]       cont_estavel;
  logic [3:0]       cont_novo;
  logic             carrega;

  function automatic logic [3:0] incrementa_sat(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  sincronizador_2ff #(.WIDTH(7)) u_sinc (
    .clk   (Clock50),
    .rst_n (Reset),
    .dado  ({Pino1, Pino2, Pino3, Pino4, Pino6, Pino9, v_sync}),
    .sinc  (pinos_sinc)
  );

  assign {p1, p2, p3, p4, p6, p9, vs_sinc} = pinos_sinc;
  assign inicio_quadro = vs_anterior & ~vs_sinc;

  // Scan sequencer: Select high phase, then Select low phase, then one update cycle.
  always_ff @(posedge Clock50 or negedge Reset) begin
    if (!Reset) begin
      estado      <= OCIOSO;
      cnt_espera  <= '0;
      vs_anterior <= 1'b0;
      Select      <= 1'b1;
      botoes      <= '0;
      presente    <= 1'b0;
    end else begin
      vs_anterior <= vs_sinc;
      case (estado)
        OCIOSO: begin
          if (inicio_quadro) begin
            estado     <= ESPERA_ALTO;
            cnt_espera <= '0;
          end
        end
        ESPERA_ALTO: begin
          if (cnt_espera == FIM) begin
            cnt_espera <= '0;
            estado     <= AMOSTRA_ALTO;
          end else begin
            cnt_espera <= cnt_espera + 1'b1;
          end
        end
        AMOSTRA_ALTO: begin
          botoes[BIT_UP]    <= ~p1;
          botoes[BIT_DOWN]  <= ~p2;
          botoes[BIT_LEFT]  <= ~p3;
          botoes[BIT_RIGHT] <= ~p4;
          botoes[BIT_B]     <= ~p6;
          botoes[BIT_C]     <= ~p9;
          Select            <= 1'b0;
          estado            <= ESPERA_BAIXO;
        end
        ESPERA_BAIXO: begin
          if (cnt_espera == FIM) begin
            cnt_espera <= '0;
            estado     <= AMOSTRA_BAIXO;
          end else begin
            cnt_espera <= cnt_espera + 1'b1;
          end
        end
        AMOSTRA_BAIXO: begin
          // A 3-button pad pulls Left and Right low while Select is low.
          botoes[BIT_A]     <= ~p6;
          botoes[BIT_START] <= ~p9;
          presente          <= ~p3 & ~p4;
          Select            <= 1'b1;
          estado            <= ATUALIZA;
        end
        ATUALIZA: estado <= OCIOSO;
        default:  estado <= OCIOSO;
      endcase
    end
  end

  assign bruto     = presente ? {1'b1, botoes} : 9'h000;
  assign cont_novo = (bruto == candidato) ? incrementa_sat(cont_estavel) : 4'd1;
  assign carrega   = (cont_novo >= LIMIAR);

  // Frame debounce and output update, only in ATUALIZA.
  always_ff @(posedge Clock50 or negedge Reset) begin
    if (!Reset) begin
      Saidas       <= '0;
      Pulsos       <= '0;
      Quadro_ok    <= 1'b0;
      candidato    <= '0;
      cont_estavel <= '0;
    end else begin
      Pulsos    <= '0;
      Quadro_ok <= 1'b0;
      if (estado == ATUALIZA) begin
        Quadro_ok    <= 1'b1;
        candidato    <= bruto;
        cont_estavel <= cont_novo;
        if (carrega) begin
          Saidas <= {3'b000, bruto};
          Pulsos <= bruto[7:0] & ~Saidas[7:0];
        end
      end
    end
  end

endmodule
